// File: rtl/cat_spi_snoop_pkg.sv
// cat_spi_snoop_pkg
// Shared definitions for the AD9361 SPI snooper:
//   - AD9361 instruction word field positions
//   - 64-bit debug record field positions
//   - decoder FSM state encoding
//   - pack_record(): assembles one debug record from its fields
package cat_spi_snoop_pkg;

  // AD9361 instruction word: wr=instr[15], n=instr[14:12] (bytes-1), addr=instr[9:0]
  localparam int INSTR_W = 16;
  localparam int WR_BIT  = 15;
  localparam int N_MSB   = 14;
  localparam int N_LSB   = 12;
  localparam int N_W     = N_MSB - N_LSB + 1;
  localparam int ADDR_W  = 10;

  // Record layout
  localparam int REC_W         = 64;
  localparam int REC_SEQ_LSB   = 56;
  localparam int REC_SEQ_W     = 8;
  localparam int REC_WR_BIT    = 55;
  localparam int REC_N_LSB     = 52;
  localparam int REC_TRUNC_BIT = 51;
  localparam int REC_OVF_BIT   = 50;
  localparam int REC_ADDR_LSB  = 40;
  localparam int REC_DATA_W    = 32;
  localparam int KEPT_BYTES    = REC_DATA_W / 8;

  typedef enum logic [2:0] {
    ST_ARM   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SKIP  = 3'd2,
    ST_INSTR = 3'd3,
    ST_DATA  = 3'd4,
    ST_EMIT  = 3'd5
  } state_t;

  // Bits [39:32] of the record are reserved and always zero.
  function automatic logic [REC_W-1:0] pack_record(
    input logic [REC_SEQ_W-1:0]  seq,
    input logic                  wr,
    input logic [N_W-1:0]        n,
    input logic                  trunc,
    input logic                  ovf,
    input logic [ADDR_W-1:0]     addr,
    input logic [REC_DATA_W-1:0] data
  );
    return {seq, wr, n, trunc, ovf, addr, 8'h00, data};
  endfunction

endpackage

// File: rtl/cat_spi_snoop_fifo.sv
// cat_spi_snoop_fifo
// Synchronous first-word-fall-through FIFO for debug records. The head entry
// is held in an output register, so dout/valid come straight from flops.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data
//   pop        : read request (ignored when empty)
//   full       : no free entry
//   dout       : head entry (zero when empty)
//   valid      : FIFO not empty
module cat_spi_snoop_fifo
  import cat_spi_snoop_pkg::*;
#(
  parameter int AW = 4,
  parameter int W  = REC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic [W-1:0] dout,
  output logic         valid
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] rd_next_s;
  logic [AW:0]   count_r;
  logic [AW:0]   count_next_s;
  logic [W-1:0]  dout_r;
  logic          valid_r;
  logic          pop_ok_s;
  logic          push_ok_s;

  assign full  = (count_r == (AW+1)'(DEPTH));
  assign dout  = dout_r;
  assign valid = valid_r;

  // Accept/pointer/occupancy arithmetic; a pop frees a slot for a same-cycle push
  always_comb begin
    pop_ok_s  = pop & valid_r;
    push_ok_s = push & (~full | pop_ok_s);
    rd_next_s = rd_ptr_r + AW'(pop_ok_s);
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + {{AW{1'b0}}, 1'b1};
      2'b01:   count_next_s = count_r - {{AW{1'b0}}, 1'b1};
      default: count_next_s = count_r;
    endcase
  end

  // Storage array (no reset needed; contents are only visible through dout_r)
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy and the registered head entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      dout_r   <= '0;
      valid_r  <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      rd_ptr_r <= rd_next_s;
      count_r  <= count_next_s;
      valid_r  <= (count_next_s != '0);
      // The next head may be the entry being written this very cycle.
      if (count_next_s == '0) begin
        dout_r <= '0;
      end else if (push_ok_s && (wr_ptr_r == rd_next_s)) begin
        dout_r <= din;
      end else begin
        dout_r <= mem_r[rd_next_s];
      end
    end
  end

endmodule

// File: rtl/cat_spi_snoop.sv
// cat_spi_snoop
// Passive decoder for the AD9361 SPI debug taps. Oversamples CE/SCLK/MOSI/MISO
// on bus_clk, decodes each transaction (16-bit instruction plus data bytes)
// and emits one 64-bit AXI-stream record per transaction via a small FIFO.
// Never drives the SPI bus.
// Ports:
//   bus_clk, bus_rst_n        : clock, asynchronous active-low reset
//   enb                       : capture enable, looked at only when CE falls
//   spi_ce/sclk/mosi/miso     : asynchronous SPI tap inputs
//   o_tdata/o_tlast/o_tvalid  : record stream (one beat per packet)
//   o_tready                  : stream consumer ready
//   dropped_cnt               : records lost to a full FIFO (saturating)
//   runt_cnt                  : transactions shorter than an instruction (saturating)
//   busy                      : a transaction is being decoded
module cat_spi_snoop
  import cat_spi_snoop_pkg::*;
#(
  parameter int FIFO_AW     = 4,
  parameter bit SAMPLE_RISE = 1'b1
) (
  input  logic        bus_clk,
  input  logic        bus_rst_n,
  input  logic        enb,
  input  logic        spi_ce,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_miso,
  output logic [63:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic [15:0] dropped_cnt,
  output logic [7:0]  runt_cnt,
  output logic        busy
);

  // Synchroniser bit positions
  localparam int L_CE   = 0;
  localparam int L_SCLK = 1;
  localparam int L_MOSI = 2;
  localparam int L_MISO = 3;

  logic [3:0]            meta_r;
  logic [3:0]            sync_r;
  logic                  ce_hist_r;
  logic                  sclk_hist_r;

  logic                  ce_fall_s;
  logic                  ce_rise_s;
  logic                  sclk_edge_s;
  logic                  data_bit_s;
  logic                  trunc_s;
  logic [REC_W-1:0]      record_s;
  logic                  fifo_full_s;
  logic                  fifo_valid_s;
  logic [REC_W-1:0]      fifo_dout_s;
  logic                  fifo_pop_s;
  logic                  push_req_s;
  logic                  push_ok_s;

  state_t                state_r;
  logic                  busy_r;
  logic [3:0]            bitcnt_r;
  logic [INSTR_W-2:0]    instr_sr_r;
  logic                  wr_r;
  logic [N_W-1:0]        n_r;
  logic [ADDR_W-1:0]     addr_r;
  logic [6:0]            byte_sr_r;
  logic [2:0]            bit_in_byte_r;
  logic [3:0]            byte_cnt_r;
  logic [REC_DATA_W-1:0] data_r;
  logic [REC_SEQ_W-1:0]  seq_r;
  logic                  ovf_r;
  logic [15:0]           dropped_cnt_r;
  logic [7:0]            runt_cnt_r;

  // Two-flop synchroniser on every line, plus history flops on CE and SCLK
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      meta_r      <= 4'b0000;
      sync_r      <= 4'b0000;
      ce_hist_r   <= 1'b0;
      sclk_hist_r <= 1'b0;
    end else begin
      meta_r      <= {spi_miso, spi_mosi, spi_sclk, spi_ce};
      sync_r      <= meta_r;
      ce_hist_r   <= sync_r[L_CE];
      sclk_hist_r <= sync_r[L_SCLK];
    end
  end

  // Edge detection, data-line selection and record assembly
  always_comb begin
    ce_fall_s = ~sync_r[L_CE] & ce_hist_r;
    ce_rise_s = sync_r[L_CE] & ~ce_hist_r;
    if (SAMPLE_RISE) begin
      sclk_edge_s = sync_r[L_SCLK] & ~sclk_hist_r;
    end else begin
      sclk_edge_s = ~sync_r[L_SCLK] & sclk_hist_r;
    end
    // Writes carry data on MOSI, reads return it on MISO.
    if (wr_r) begin
      data_bit_s = sync_r[L_MOSI];
    end else begin
      data_bit_s = sync_r[L_MISO];
    end
    // Truncated if a byte is partial or the byte count differs from n+1.
    trunc_s  = (bit_in_byte_r != 3'd0) || (byte_cnt_r != ({1'b0, n_r} + 4'd1));
    record_s = pack_record(seq_r, wr_r, n_r, trunc_s, ovf_r, addr_r, data_r);
  end

  // A push into a full FIFO still succeeds when the consumer pops in the same cycle.
  assign fifo_pop_s = fifo_valid_s & o_tready;
  assign push_req_s = (state_r == ST_EMIT);
  assign push_ok_s  = push_req_s & (~fifo_full_s | fifo_pop_s);

  // Transaction decoder FSM with its datapath and counters
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state_r       <= ST_ARM;
      busy_r        <= 1'b0;
      bitcnt_r      <= 4'd0;
      instr_sr_r    <= '0;
      wr_r          <= 1'b0;
      n_r           <= '0;
      addr_r        <= '0;
      byte_sr_r     <= 7'd0;
      bit_in_byte_r <= 3'd0;
      byte_cnt_r    <= 4'd0;
      data_r        <= '0;
      seq_r         <= '0;
      ovf_r         <= 1'b0;
      dropped_cnt_r <= 16'd0;
      runt_cnt_r    <= 8'd0;
    end else begin
      case (state_r)
        // Wait for an idle bus so a transaction already in flight is never decoded.
        ST_ARM: begin
          if (sync_r[L_CE]) begin
            state_r <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (ce_fall_s) begin
            if (enb) begin
              state_r       <= ST_INSTR;
              busy_r        <= 1'b1;
              bitcnt_r      <= 4'd0;
              instr_sr_r    <= '0;
              byte_sr_r     <= 7'd0;
              bit_in_byte_r <= 3'd0;
              byte_cnt_r    <= 4'd0;
              data_r        <= '0;
            end else begin
              state_r <= ST_SKIP;
            end
          end
        end
        ST_SKIP: begin
          if (ce_rise_s) begin
            state_r <= ST_IDLE;
          end
        end
        ST_INSTR: begin
          if (ce_rise_s) begin
            // Still in INSTR means fewer than 16 bits arrived.
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            if (runt_cnt_r != 8'hFF) begin
              runt_cnt_r <= runt_cnt_r + 8'd1;
            end
          end else if (sclk_edge_s) begin
            instr_sr_r <= {instr_sr_r[INSTR_W-3:0], sync_r[L_MOSI]};
            bitcnt_r   <= bitcnt_r + 4'd1;
            if (bitcnt_r == 4'd15) begin
              // instr_sr_r holds instr[15:1]; the live bit is instr[0].
              wr_r    <= instr_sr_r[WR_BIT-1];
              n_r     <= instr_sr_r[N_MSB-1:N_LSB-1];
              addr_r  <= {instr_sr_r[ADDR_W-2:0], sync_r[L_MOSI]};
              state_r <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (ce_rise_s) begin
            state_r <= ST_EMIT;
          end else if (sclk_edge_s) begin
            byte_sr_r     <= {byte_sr_r[5:0], data_bit_s};
            bit_in_byte_r <= bit_in_byte_r + 3'd1;
            if (bit_in_byte_r == 3'd7) begin
              if (byte_cnt_r < 4'(KEPT_BYTES)) begin
                case (byte_cnt_r[1:0])
                  2'd0:    data_r[31:24] <= {byte_sr_r, data_bit_s};
                  2'd1:    data_r[23:16] <= {byte_sr_r, data_bit_s};
                  2'd2:    data_r[15:8]  <= {byte_sr_r, data_bit_s};
                  2'd3:    data_r[7:0]   <= {byte_sr_r, data_bit_s};
                  default: data_r        <= data_r;
                endcase
              end
              if (byte_cnt_r != 4'd15) begin
                byte_cnt_r <= byte_cnt_r + 4'd1;
              end
            end
          end
        end
        // Record goes into the FIFO this cycle; seq advances even on a drop.
        ST_EMIT: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          seq_r   <= seq_r + 8'd1;
          if (push_ok_s) begin
            ovf_r <= 1'b0;
          end else begin
            ovf_r <= 1'b1;
            if (dropped_cnt_r != 16'hFFFF) begin
              dropped_cnt_r <= dropped_cnt_r + 16'd1;
            end
          end
        end
        default: begin
          state_r <= ST_ARM;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  cat_spi_snoop_fifo #(
    .AW (FIFO_AW),
    .W  (REC_W)
  ) u_fifo (
    .clk   (bus_clk),
    .rst_n (bus_rst_n),
    .push  (push_ok_s),
    .din   (record_s),
    .pop   (fifo_pop_s),
    .full  (fifo_full_s),
    .dout  (fifo_dout_s),
    .valid (fifo_valid_s)
  );

  assign o_tdata     = fifo_dout_s;
  assign o_tvalid    = fifo_valid_s;
  assign o_tlast     = fifo_valid_s;
  assign dropped_cnt = dropped_cnt_r;
  assign runt_cnt    = runt_cnt_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_cat_spi_snoop.sv
// tb_cat_spi_snoop
// Directed bench for cat_spi_snoop. Stimulus pushes the hand-computed record
// for each transaction into exp_q; an independent monitor compares every
// accepted stream beat against the head of the queue.
module tb_cat_spi_snoop;

  logic        bus_clk;
  logic        bus_rst_n;
  logic        enb;
  logic        spi_ce;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic [63:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic [15:0] dropped_cnt;
  logic [7:0]  runt_cnt;
  logic        busy;

  int          compared;
  int          mismatched;
  logic [63:0] exp_q[$];

  cat_spi_snoop #(
    .FIFO_AW     (2),
    .SAMPLE_RISE (1'b1)
  ) dut (
    .bus_clk     (bus_clk),
    .bus_rst_n   (bus_rst_n),
    .enb         (enb),
    .spi_ce      (spi_ce),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .o_tdata     (o_tdata),
    .o_tlast     (o_tlast),
    .o_tvalid    (o_tvalid),
    .o_tready    (o_tready),
    .dropped_cnt (dropped_cnt),
    .runt_cnt    (runt_cnt),
    .busy        (busy)
  );

  // 100 MHz bus clock
  initial begin
    bus_clk = 1'b0;
    forever #5 bus_clk = ~bus_clk;
  end

  // Safety net against a hung run
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: sample mid-cycle, before the edge on which the beat transfers
  initial begin
    logic [63:0] exp_rec;
    forever begin
      @(negedge bus_clk);
      if (bus_rst_n && o_tvalid && o_tready) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL record: got unexpected %h, expected no record", o_tdata);
        end else begin
          exp_rec = exp_q.pop_front();
          if ((o_tdata !== exp_rec) || (o_tlast !== 1'b1)) begin
            mismatched++;
            $display("FAIL record: got %h tlast=%b, expected %h tlast=1", o_tdata, o_tlast, exp_rec);
          end
        end
      end
    end
  end

  task automatic ticks(input int n);
    repeat (n) @(posedge bus_clk);
    #1;
  endtask

  // One SPI transaction: bits go out MSB-first from bit 79 of each vector.
  // sclk idles low, data changes while low and is sampled on the rising edge.
  // If rst_bit >= 0 a reset pulse is applied just before that bit.
  task automatic spi_txn(input logic [79:0] mosi_v, input logic [79:0] miso_v,
                         input int nbits, input int rst_bit);
    spi_ce = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        chk("busy_mid_txn", 64'(busy), 64'd1);
        bus_rst_n = 1'b0;
        ticks(2);
        chk("busy_in_reset", 64'(busy), 64'd0);
        bus_rst_n = 1'b1;
      end
      spi_mosi = mosi_v[79-i];
      spi_miso = miso_v[79-i];
      spi_sclk = 1'b0;
      ticks(5);
      spi_sclk = 1'b1;
      ticks(5);
    end
    spi_sclk = 1'b0;
    ticks(5);
    spi_ce   = 1'b1;
    spi_mosi = 1'b0;
    spi_miso = 1'b0;
    ticks(12);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0) && (n < 2000)) begin
      ticks(1);
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    bus_rst_n = 1'b0;
    ticks(3);
    bus_rst_n = 1'b1;
    ticks(6);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    bus_rst_n  = 1'b0;
    enb        = 1'b1;
    spi_ce     = 1'b1;
    spi_sclk   = 1'b0;
    spi_mosi   = 1'b0;
    spi_miso   = 1'b0;
    o_tready   = 1'b1;
    ticks(4);

    chk("rst_tdata",   o_tdata, 64'h0);
    chk("rst_tvalid",  64'(o_tvalid), 64'd0);
    chk("rst_tlast",   64'(o_tlast), 64'd0);
    chk("rst_dropped", 64'(dropped_cnt), 64'd0);
    chk("rst_runt",    64'(runt_cnt), 64'd0);
    chk("rst_busy",    64'(busy), 64'd0);
    bus_rst_n = 1'b1;
    ticks(10);

    // Single-byte write: seq 0
    exp_q.push_back(64'h0080_3700_5A00_0000);
    spi_txn({16'h8037, 8'h5A, 56'h0}, 80'h0, 24, -1);
    // Read, MISO returns 0xC3: seq 1
    exp_q.push_back(64'h0102_4700_C300_0000);
    spi_txn({16'h0247, 64'h0}, {16'h0, 8'hC3, 56'h0}, 24, -1);
    // Six-byte write (n=5): only the first four bytes kept, seq 2
    exp_q.push_back(64'h02D0_1200_1122_3344);
    spi_txn({16'hD012, 48'h1122_3344_5566, 16'h0}, 80'h0, 64, -1);
    // n=2 but only two bytes sent: trunc set, seq 3
    exp_q.push_back(64'h03A8_5500_AABB_0000);
    spi_txn({16'hA055, 16'hAABB, 48'h0}, 80'h0, 32, -1);
    // Runt: 10 clocks then CE released
    spi_txn({16'h8037, 64'h0}, 80'h0, 10, -1);
    // Capture disabled at CE fall: no record, seq untouched
    enb = 1'b0;
    spi_txn({16'h8037, 8'hEE, 56'h0}, 80'h0, 24, -1);
    enb = 1'b1;
    // Seq continues at 4 after runt and skipped transactions
    exp_q.push_back(64'h0480_3700_4400_0000);
    spi_txn({16'h8037, 8'h44, 56'h0}, 80'h0, 24, -1);
    wait_drain("drain_basic");
    chk("runt_cnt", 64'(runt_cnt), 64'd1);
    chk("dropped_basic", 64'(dropped_cnt), 64'd0);

    // Overflow: 4-deep FIFO, consumer stalled, six transactions
    do_reset();
    o_tready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      spi_txn({16'h8037, 8'h10 + 8'(k), 56'h0}, 80'h0, 24, -1);
    end
    exp_q.push_back(64'h0080_3700_1000_0000);
    exp_q.push_back(64'h0180_3700_1100_0000);
    exp_q.push_back(64'h0280_3700_1200_0000);
    exp_q.push_back(64'h0380_3700_1300_0000);
    chk("ovf_dropped", 64'(dropped_cnt), 64'd2);
    chk("ovf_tvalid",  64'(o_tvalid), 64'd1);
    chk("ovf_head",    o_tdata, 64'h0080_3700_1000_0000);
    ticks(1);
    o_tready = 1'b1;
    wait_drain("drain_ovf");
    // Next record carries ovf=1 and seq=6
    exp_q.push_back(64'h0684_3700_7700_0000);
    spi_txn({16'h8037, 8'h77, 56'h0}, 80'h0, 24, -1);
    wait_drain("drain_ovf_rec");

    // Reset three data bits into a write; CE stays low five more bits
    spi_txn({16'h8037, 8'hF0, 56'h0}, 80'h0, 24, 19);
    chk("rst_mid_dropped", 64'(dropped_cnt), 64'd0);
    chk("rst_mid_tvalid",  64'(o_tvalid), 64'd0);
    exp_q.push_back(64'h0080_3700_9900_0000);
    spi_txn({16'h8037, 8'h99, 56'h0}, 80'h0, 24, -1);
    wait_drain("drain_final");
    ticks(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
